// File: rtl/uart_tx_pkg.sv
// Shared types, frame constants and frame-building helpers for the UART transmitter.
package uart_tx_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } tx_state_e;

    localparam int unsigned BAUD_DIV_DEFAULT = 5208;
    localparam int unsigned FRAME_W          = 11;

    localparam logic [3:0] FRAME_LEN_MIN = 4'd9;
    localparam logic [3:0] FRAME_LEN_MID = 4'd10;
    localparam logic [3:0] FRAME_LEN_MAX = 4'd11;

    function automatic logic [3:0] frame_len(input logic bit8, input logic parity_en);
        logic [3:0] len;
        case ({bit8, parity_en})
            2'b00:   len = FRAME_LEN_MIN;
            2'b11:   len = FRAME_LEN_MAX;
            default: len = FRAME_LEN_MID;
        endcase
        return len;
    endfunction

    // Complete frame, LSB is the start bit; positions past the stop bit stay at 1.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data,
                                                       input logic       bit8,
                                                       input logic       parity_en,
                                                       input logic       odd);
        logic [7:0]         bits;
        logic               par;
        logic [FRAME_W-1:0] frame;
        bits     = bit8 ? data : {1'b0, data[6:0]};
        par      = (^bits) ^ odd;
        frame    = '1;
        frame[0] = 1'b0;
        if (bit8) begin
            frame[8:1] = bits;
            frame[9]   = parity_en ? par : 1'b1;
        end else begin
            frame[7:1] = bits[6:0];
            frame[8]   = parity_en ? par : 1'b1;
        end
        return frame;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-period counter: counts 0..BAUD_DIV-1 and flags the wrap cycle.
module uart_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_shift.sv
// UART transmitter: 7/8 data bits, optional parity, one stop bit, LSB first.
module uart_tx_shift
    import uart_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd,
    output logic       tx,
    output logic       tx_rdy,
    output logic       tx_done
);

    tx_state_e          state_q;
    logic [FRAME_W-1:0] shift_q;
    logic [3:0]         bit_cnt_q;
    logic [3:0]         len_q;
    logic [3:0]         bit_cnt_inc;
    logic               tick;
    logic               baud_clr;

    // Holding the counter clear while idle makes it restart at 0 on the accepting edge.
    assign baud_clr    = (state_q == StIdle);
    assign bit_cnt_inc = bit_cnt_q + 4'd1;
    assign tx          = shift_q[0];

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            len_q     <= FRAME_LEN_MIN;
            tx_rdy    <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        shift_q   <= build_frame(data, bit8, parity_en, odd);
                        len_q     <= frame_len(bit8, parity_en);
                        bit_cnt_q <= '0;
                        tx_rdy    <= 1'b0;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (tick) begin
                        if (bit_cnt_inc == len_q) begin
                            shift_q   <= '1;
                            bit_cnt_q <= '0;
                            tx_rdy    <= 1'b1;
                            tx_done   <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            shift_q   <= {1'b1, shift_q[FRAME_W-1:1]};
                            bit_cnt_q <= bit_cnt_inc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_shift.sv
// Self-checking bench for uart_tx_shift: directed frame table, corner sequences, random traffic.
module tb_uart_tx_shift;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data = 8'h00;
    logic       bit8 = 1'b0;
    logic       parity_en = 1'b0;
    logic       odd = 1'b0;
    logic       tx;
    logic       tx_rdy;
    logic       tx_done;

    int n_checks = 0;
    int n_err    = 0;
    int dut_done_cnt = 0;
    int exp_done_cnt = 0;
    bit mon_en = 1'b0;

    uart_tx_shift #(
        .BAUD_DIV(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data     (data),
        .bit8     (bit8),
        .parity_en(parity_en),
        .odd      (odd),
        .tx       (tx),
        .tx_rdy   (tx_rdy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        b8;
        logic        pe;
        logic        od;
        int          len;
        logic [10:0] pat;   // bit i = line level during bit period i
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame as a list of bits, and time since acceptance in clocks.
    function automatic void model_frame(input logic [7:0] d, input logic b8, input logic pe,
                                        input logic od, output bit f[0:10], output int len);
        int nd;
        int ones;
        nd   = b8 ? 8 : 7;
        ones = 0;
        for (int i = 0; i < 11; i++) f[i] = 1'b1;
        f[0] = 1'b0;
        len  = 1;
        for (int i = 0; i < nd; i++) begin
            f[len] = d[i];
            ones   = ones + int'(d[i]);
            len    = len + 1;
        end
        if (pe) begin
            f[len] = ((ones % 2) == 1) ^ od;
            len    = len + 1;
        end
        f[len] = 1'b1;
        len    = len + 1;
    endfunction

    bit m_active;
    int m_off;
    int m_len;
    bit m_bits[0:10];
    bit exp_tx, exp_rdy, exp_done;

    always @(posedge clk or negedge reset) begin : model
        int nxt;
        int flen;
        bit fb[0:10];
        if (!reset) begin
            m_active <= 1'b0;
            m_off    <= 0;
            exp_tx   <= 1'b1;
            exp_rdy  <= 1'b1;
            exp_done <= 1'b0;
        end else if (m_active) begin
            nxt = m_off + 1;
            m_off <= nxt;
            if (nxt == m_len * D) begin
                m_active <= 1'b0;
                exp_tx   <= 1'b1;
                exp_rdy  <= 1'b1;
                exp_done <= 1'b1;
            end else begin
                exp_tx   <= m_bits[nxt / D];
                exp_done <= 1'b0;
            end
        end else begin
            exp_done <= 1'b0;
            if (load) begin
                model_frame(data, bit8, parity_en, odd, fb, flen);
                m_bits   <= fb;
                m_len    <= flen;
                m_active <= 1'b1;
                m_off    <= 0;
                exp_tx   <= fb[0];
                exp_rdy  <= 1'b0;
            end else begin
                exp_tx <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("monitor tx/rdy/done", {29'd0, tx, tx_rdy, tx_done},
                {29'd0, exp_tx, exp_rdy, exp_done});
            if (tx_done === 1'b1) dut_done_cnt++;
            if (exp_done) exp_done_cnt++;
        end
    end

    task automatic present(input vec_t v);
        data      = v.data;
        bit8      = v.b8;
        parity_en = v.pe;
        odd       = v.od;
        load      = 1'b1;
    endtask

    // Call with load already presented; checks every clock of the frame against v.pat.
    task automatic run_frame(input string tag, input vec_t v, input int glitch_at,
                             input int abort_at, input bit chain, input vec_t nxt);
        int last;
        last = v.len * D;
        @(negedge clk);
        load      = 1'b0;
        data      = 8'($urandom);
        bit8      = 1'($urandom);
        parity_en = 1'($urandom);
        odd       = 1'($urandom);
        for (int k = 0; k <= last; k++) begin
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1 chk({tag, " reset mid-frame"}, {29'd0, tx, tx_rdy, tx_done}, 32'b110);
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk);
                    chk({tag, " held in reset"}, {29'd0, tx, tx_rdy, tx_done}, 32'b110);
                end
                #2 reset = 1'b1;
                @(negedge clk);
                chk({tag, " after release"}, {29'd0, tx, tx_rdy, tx_done}, 32'b110);
                return;
            end
            if (k < last) begin
                chk($sformatf("%s k%0d", tag, k), {29'd0, tx, tx_rdy, tx_done},
                    {29'd0, v.pat[k / D], 2'b00});
            end else begin
                chk($sformatf("%s end", tag), {29'd0, tx, tx_rdy, tx_done}, 32'b111);
                if (chain) present(nxt);
            end
            if (k == glitch_at) begin
                load = 1'b1;
                data = ~v.data;
                bit8 = ~v.b8;
            end else if (k == glitch_at + 1) begin
                load = 1'b0;
            end
            if (k < last) @(negedge clk);
        end
        if (!chain) begin
            @(negedge clk);
            chk({tag, " idle"}, {29'd0, tx, tx_rdy, tx_done}, 32'b110);
        end
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 10, 11'b11010101010};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 1'b0, 11, 11'b10101000110};
        vecs[2] = '{8'hC1, 1'b0, 1'b1, 1'b1, 10, 11'b11110000010};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 10, 11'b11111111110};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1,  9, 11'b11100000000};
        vecs[5] = '{8'h0F, 1'b1, 1'b1, 1'b1, 11, 11'b11000011110};
        vecs[6] = '{8'h6B, 1'b0, 1'b1, 1'b0, 10, 11'b11111010110};

        #1 reset = 1'b0;
        #2 chk("reset state", {29'd0, tx, tx_rdy, tx_done}, 32'b110);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("idle after reset", {29'd0, tx, tx_rdy, tx_done}, 32'b110);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            present(vecs[i]);
            run_frame($sformatf("vec%0d", i), vecs[i], -1, -1, 1'b0, vecs[i]);
        end

        // Second load mid-frame must leave the waveform untouched.
        @(negedge clk);
        present(vecs[0]);
        run_frame("midload", vecs[0], 13, -1, 1'b0, vecs[0]);

        // Reset 17 clocks into a frame, then a clean 0xFF frame.
        @(negedge clk);
        present(vecs[1]);
        run_frame("abort", vecs[1], -1, 17, 1'b0, vecs[1]);
        @(negedge clk);
        present(vecs[3]);
        run_frame("post-abort FF", vecs[3], -1, -1, 1'b0, vecs[3]);

        // Load while tx_done is high: next start bit follows immediately.
        @(negedge clk);
        present(vecs[0]);
        run_frame("b2b first", vecs[0], -1, -1, 1'b1, vecs[2]);
        run_frame("b2b second", vecs[2], -1, -1, 1'b0, vecs[2]);

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            load      = ($urandom_range(0, 5) == 0);
            data      = 8'($urandom);
            bit8      = 1'($urandom);
            parity_en = 1'($urandom);
            odd       = 1'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
        end
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        chk("tx_done pulse count", dut_done_cnt, exp_done_cnt);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
